// File: rtl/frac_mac_multi.sv
// Multi-channel fractional multiply-accumulate: acc[ch] += (in * multiple) >>> DIVISOR_BITS,
// with a shift-add multiplier (one multiplier bit per clock, early exit), optional rounding and saturation.
module frac_mac_multi #(
    parameter int DATA_W       = 16,
    parameter int DIVISOR_BITS = 7,
    parameter int ACC_W        = 32,
    parameter int CHANNELS     = 4,
    parameter int ROUND        = 0,
    localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in,
    input  logic [DIVISOR_BITS-1:0]  multiple,
    input  logic [CH_W-1:0]          in_channel,
    input  logic [CHANNELS-1:0]      clear_mask,
    input  logic [CH_W-1:0]          acc_sel,
    output logic signed [ACC_W-1:0]  acc_out,
    output logic [CHANNELS-1:0]      sat,
    output logic                     done
);

    localparam int PROD_W = DATA_W + DIVISOR_BITS + 1;
    localparam int K_W    = $clog2(DIVISOR_BITS + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_ACC  = 2'd2;

    localparam logic signed [PROD_W-1:0] RND_TERM =
        (ROUND != 0) ? PROD_W'(1) <<< (DIVISOR_BITS - 1) : '0;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [1:0]                state_q, state_d;
    logic signed [DATA_W-1:0]  in_q, in_d;
    logic [CH_W-1:0]           ch_q, ch_d;
    logic signed [PROD_W-1:0]  prod_q, prod_d;
    logic [DIVISOR_BITS-1:0]   rem_q, rem_d;
    logic [K_W-1:0]            k_q, k_d;
    logic signed [ACC_W-1:0]   acc_q [CHANNELS];
    logic [CHANNELS-1:0]       sat_q;
    logic                      done_q;

    logic signed [PROD_W-1:0]  in_port_ext;
    logic signed [PROD_W-1:0]  in_ext;
    logic signed [PROD_W-1:0]  rounded;
    logic signed [ACC_W:0]     scaled;
    logic signed [ACC_W-1:0]   cur_acc;
    logic signed [ACC_W:0]     sum;
    logic                      ovf;
    logic signed [ACC_W-1:0]   clamped;

    assign in_port_ext = PROD_W'(in);
    assign in_ext      = PROD_W'(in_q);

    // NOTE: every signal assigned in a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        in_d    = in_q;
        ch_d    = ch_q;
        prod_d  = prod_q;
        rem_d   = rem_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    in_d    = in;
                    ch_d    = in_channel;
                    prod_d  = multiple[0] ? in_port_ext : '0;
                    rem_d   = multiple >> 1;
                    k_d     = K_W'(1);
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                if (rem_q == '0) begin
                    state_d = S_ACC;
                end else begin
                    if (rem_q[0]) begin
                        prod_d = prod_q + (in_ext <<< k_q);
                    end
                    rem_d = rem_q >> 1;
                    k_d   = k_q + K_W'(1);
                end
            end
            S_ACC:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Channel lookups compare against each index so an out-of-range select simply matches nothing.
    always_comb begin
        cur_acc = '0;
        acc_out = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch_q == CH_W'(i)) begin
                cur_acc = acc_q[i];
            end
            if (acc_sel == CH_W'(i)) begin
                acc_out = acc_q[i];
            end
        end
    end

    assign rounded = prod_q + RND_TERM;
    assign scaled  = (ACC_W + 1)'(rounded >>> DIVISOR_BITS);
    assign sum     = $signed({cur_acc[ACC_W-1], cur_acc}) + scaled;
    assign ovf     = sum[ACC_W] ^ sum[ACC_W-1];

    always_comb begin
        clamped = sum[ACC_W-1:0];
        if (ovf) begin
            clamped = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            in_q    <= '0;
            ch_q    <= '0;
            prod_q  <= '0;
            rem_q   <= '0;
            k_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            in_q    <= in_d;
            ch_q    <= ch_d;
            prod_q  <= prod_d;
            rem_q   <= rem_d;
            k_q     <= k_d;
            done_q  <= (state_q == S_ACC);
        end
    end

    // NOTE: the accumulator array is reset explicitly because readout must be zero straight after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc_q[i] <= '0;
            end
            sat_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (clear_mask[i]) begin
                    acc_q[i] <= '0;
                    sat_q[i] <= 1'b0;
                end else if ((state_q == S_ACC) && (ch_q == CH_W'(i))) begin
                    acc_q[i] <= clamped;
                    if (ovf) begin
                        sat_q[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign in_ready = (state_q == S_IDLE);
    assign sat      = sat_q;
    assign done     = done_q;

endmodule

// File: tb/tb_frac_mac_multi.sv
// Directed bench for frac_mac_multi: default, rounding, and narrow (20-bit, 3-channel) instances
// share one stimulus stream; each check compares against hand-computed values.
module tb_frac_mac_multi;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid = 1'b0;
    logic signed [15:0] in = '0;
    logic [6:0]         multiple = '0;
    logic [1:0]         in_channel = '0;
    logic [3:0]         clear_mask = '0;
    logic [1:0]         acc_sel = '0;

    logic               rdy_m, rdy_r, rdy_n;
    logic               done_m, done_r, done_n;
    logic signed [31:0] acc_m, acc_r;
    logic signed [19:0] acc_n;
    logic [3:0]         sat_m, sat_r;
    logic [2:0]         sat_n;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int lat;
    int rdy_low;
    int d0;

    always #5 clock = ~clock;

    frac_mac_multi u_main (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy_m), .in(in),
        .multiple(multiple), .in_channel(in_channel), .clear_mask(clear_mask),
        .acc_sel(acc_sel), .acc_out(acc_m), .sat(sat_m), .done(done_m)
    );

    frac_mac_multi #(.ROUND(1)) u_rnd (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy_r), .in(in),
        .multiple(multiple), .in_channel(in_channel), .clear_mask(clear_mask),
        .acc_sel(acc_sel), .acc_out(acc_r), .sat(sat_r), .done(done_r)
    );

    frac_mac_multi #(.ACC_W(20), .CHANNELS(3)) u_nar (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy_n), .in(in),
        .multiple(multiple), .in_channel(in_channel), .clear_mask(clear_mask[2:0]),
        .acc_sel(acc_sel), .acc_out(acc_n), .sat(sat_n), .done(done_n)
    );

    always @(posedge clock) begin
        if (done_m) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic sel(input logic [1:0] s);
        acc_sel = s;
        #1;
    endtask

    task automatic clear_all();
        @(negedge clock);
        clear_mask = 4'hF;
        @(negedge clock);
        clear_mask = 4'h0;
    endtask

    // One transaction; returns clocks from accept to done. clear_val is applied on edge clr_edge.
    task automatic run(input logic signed [15:0] d, input logic [6:0] m, input logic [1:0] ch,
                       input int clr_edge, input logic [3:0] clr_val);
        int guard;
        @(negedge clock);
        guard = 0;
        while (!rdy_m && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        in = d;
        multiple = m;
        in_channel = ch;
        in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        in = 16'sh5a5a;
        multiple = 7'h55;
        lat = 0;
        rdy_low = rdy_m ? 0 : 1;
        clear_mask = (clr_edge == 1) ? clr_val : 4'h0;
        while (!done_m && lat < 100) begin
            @(negedge clock);
            lat++;
            if (!rdy_m) rdy_low++;
            clear_mask = (lat == clr_edge - 1) ? clr_val : 4'h0;
        end
        clear_mask = 4'h0;
    endtask

    initial begin
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        sel(2'd0);
        check("reset_ready", rdy_m, 1);
        check("reset_done", done_m, 0);
        check("reset_acc0", acc_m, 0);
        check("reset_sat", sat_m, 0);

        run(16'sd1000, 7'd64, 2'd0, -1, 4'h0);
        check("t1_latency", lat, 8);
        check("t1_ready_low", rdy_low, 8);
        check("t1_ready_back", rdy_m, 1);
        sel(2'd0);
        check("t1_acc0", acc_m, 500);
        @(negedge clock);
        check("t1_done_pulse", done_m, 0);

        clear_all();
        sel(2'd0);
        check("clear_acc0", acc_m, 0);

        run(-16'sd1000, 7'd127, 2'd1, -1, 4'h0);
        check("t2_latency", lat, 8);
        sel(2'd1);
        check("t2_floor", acc_m, -993);
        check("t2_round", acc_r, -992);
        run(16'sd1000, 7'd1, 2'd1, -1, 4'h0);
        check("t2_m1_latency", lat, 2);
        sel(2'd1);
        check("t2_m1_floor", acc_m, -986);
        check("t2_m1_round", acc_r, -984);
        run(16'sd1000, 7'd0, 2'd1, -1, 4'h0);
        check("t2_m0_latency", lat, 2);
        sel(2'd1);
        check("t2_m0_floor", acc_m, -986);
        check("t2_m0_round", acc_r, -984);

        clear_all();
        for (int i = 0; i < 16; i++) run(16'sd32767, 7'd127, 2'd2, -1, 4'h0);
        sel(2'd2);
        check("t3_acc16", acc_n, 520176);
        check("t3_sat16", sat_n, 0);
        run(16'sd32767, 7'd127, 2'd2, -1, 4'h0);
        sel(2'd2);
        check("t3_acc17", acc_n, 524287);
        check("t3_sat17", sat_n, 3'b100);
        check("t3_wide_acc2", acc_m, 552687);
        run(16'sd1000, 7'd64, 2'd0, -1, 4'h0);
        check("t3_sat_sticky", sat_n, 3'b100);

        run(16'sd256, 7'd64, 2'd2, 8, 4'b0100);
        sel(2'd2);
        check("t5_acc2_main", acc_m, 0);
        check("t5_acc2_nar", acc_n, 0);
        check("t5_sat_nar", sat_n, 0);
        sel(2'd0);
        check("t5_acc0_main", acc_m, 500);
        check("t5_acc0_nar", acc_n, 500);

        clear_all();
        @(negedge clock);
        in = 16'sd256;
        multiple = 7'd64;
        in_valid = 1'b1;
        d0 = done_cnt;
        for (int ch = 0; ch < 4; ch++) begin
            int guard;
            in_channel = 2'(ch);
            @(posedge clock);
            guard = 0;
            do begin
                @(negedge clock);
                guard++;
            end while (!rdy_m && guard < 100);
        end
        in_valid = 1'b0;
        @(negedge clock);
        check("t4_done_count", done_cnt - d0, 4);
        for (int ch = 0; ch < 4; ch++) begin
            sel(2'(ch));
            check($sformatf("t4_acc%0d", ch), acc_m, 128);
        end

        run(16'sd1000, 7'd64, 2'd3, -1, 4'h0);
        check("oor_latency", lat, 8);
        check("oor_sat_nar", sat_n, 0);
        for (int ch = 0; ch < 3; ch++) begin
            sel(2'(ch));
            check($sformatf("oor_nar_acc%0d", ch), acc_n, 128);
        end
        sel(2'd3);
        check("oor_main_acc3", acc_m, 628);

        @(negedge clock);
        in = 16'sd1000;
        multiple = 7'd64;
        in_channel = 2'd0;
        in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("t6_ready", rdy_m, 1);
        check("t6_done", done_m, 0);
        for (int ch = 0; ch < 4; ch++) begin
            sel(2'(ch));
            check($sformatf("t6_acc%0d", ch), acc_m, 0);
        end
        reset = 1'b0;
        run(16'sd1000, 7'd64, 2'd0, -1, 4'h0);
        check("t6_latency", lat, 8);
        sel(2'd0);
        check("t6_acc0", acc_m, 500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
